banked_dual_sram: RTL and testbench
===================================

# banked_dual_sram

Parametrised multi-bank dual-port SRAM for the dot-product datapath: one write port targets a single bank, and one read port fetches the same address from every bank in parallel, returning a full operand vector per access. It adds several behaviours to the single-bank Dual_SRAM:
- a registered read with a valid strobe;
- a sequenced, one-address-per-cycle memory clear with a busy flag;
- optional write-to-read bypass.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one word
- ADDR_WIDTH, 4, address width per bank
- RAM_DEPTH, 1 << ADDR_WIDTH, words per bank
- NUM_BANKS, 4, number of banks (≥1)
- BANK_WIDTH, $clog2(NUM_BANKS) (min 1), width of the bank select

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- Mem_Clear  in  1  request a full-array clear
- Chip_Select  in  1  gates all reads and writes
- En_Write  in  1  write enable
- Write_Bank  in  BANK_WIDTH  target bank of the write
- Write_Addr  in  ADDR_WIDTH  write address
- Write_Data  in  DATA_WIDTH  write data
- En_Read  in  1  read enable
- Read_Addr  in  ADDR_WIDTH  read address, applied to all banks
- Read_Data  out  NUM_BANKS*DATA_WIDTH  bank b occupies bits [b*DATA_WIDTH +: DATA_WIDTH]
- Read_Valid  out  1  Read_Data updated by the previous edge's read
- Clear_Busy  out  1  clear sequence in progress

## Operation
- **States:**
  - IDLE: normal access.
  - CLEAR: internal counter Clr_Addr walks 0 to RAM_DEPTH-1.
- **IDLE to CLEAR:** Mem_Clear sampled high. Chip_Select is not required. Clr_Addr loads 0.
- **CLEAR, each edge:** write 0 to address Clr_Addr in every bank, then increment. The edge that clears RAM_DEPTH-1 returns the block to IDLE.
- **Mem_Clear during CLEAR:** ignored; there is no restart.
- **Write:** when Chip_Select & En_Write in IDLE and Mem_Clear low, bank[Write_Bank][Write_Addr] ← Write_Data. A Write_Bank ≥ NUM_BANKS drops the write silently.
- **Read:** when Chip_Select & En_Read in IDLE and Mem_Clear low:
  - Read_Data ← {bank[NUM_BANKS-1][Read_Addr], …, bank[0][Read_Addr]};
  - Read_Valid ← 1.
- **No read performed** (including during CLEAR, or with Mem_Clear high): Read_Valid ← 0 and Read_Data holds.
- **Mem_Clear with a read/write in the same cycle:** the clear wins and the access is discarded.
- **Read and write to the same address, same edge:** the written bank's lane follows Configuration; the other lanes return stored data.
- **rst:** aborts any clear and returns to IDLE. Array contents are not modified, so a partially cleared array remains.

## Timing
- Reset values: Read_Data = 0, Read_Valid = 0, Clear_Busy = 0, state IDLE, Clr_Addr = 0.
- **Read latency:** 1 cycle. With the read sampled at edge N, Read_Data and Read_Valid are valid after edge N. Read_Valid is a one-cycle strobe per read; back-to-back reads give continuous Read_Valid.
- **Write:** visible to a read sampled at edge N+1 or later.
- **Clear_Busy:** high for exactly RAM_DEPTH cycles, starting after the edge that samples Mem_Clear. The first access accepted is at the edge where Clear_Busy is low.
- **Clr_Addr:** saturates at RAM_DEPTH-1 and never wraps into a second pass.

## Configuration
- Macro: SRAM_BYPASS_EN.
- **Defined:** a same-edge read/write collision on the same address returns Write_Data in lane Write_Bank (write-first).
- **Undefined:** that lane returns the pre-write contents (read-first). In both modes the array holds Write_Data afterwards.

## Test plan
- **Reset then read:** rst for 2 cycles, then read addr 0 → Read_Data = 0 and Read_Valid = 0 during reset. After the read edge, Read_Valid = 1.
- **Fill then vector read (NUM_BANKS=4):** write bank b, addr a with value 16*b + a for all b and a. Read addr 3 → Read_Data = {8'd51, 8'd35, 8'd19, 8'd3}, Read_Valid = 1 for one cycle.
- **Clear sequence:** fill, then pulse Mem_Clear for 1 cycle → Clear_Busy high for exactly 16 cycles. Read/write attempts during that window are ignored with Read_Valid = 0. Afterwards every address reads 0.
- **Clear collision:** Mem_Clear with En_Write to bank 1, addr 5, value 8'hAA → write dropped; bank 1 addr 5 reads 0 after the clear.
- **Read/write collision:** addr 7 bank 2 holds 8'h11. Write 8'h22 to it while reading addr 7 in the same cycle → lane 2 = 8'h22 with SRAM_BYPASS_EN, 8'h11 without. The next read returns 8'h22 in both modes.
- **Reset mid-clear:** assert rst 5 cycles into a clear → Clear_Busy = 0 next cycle. Addrs 0–4 read 0; addrs 5–15 retain their old data.

Source files
------------

// File: rtl/banked_dual_sram.sv
`default_nettype none
// ============================================================================
// Module   : banked_dual_sram
// Brief    : Multi-bank dual-port SRAM. Single-bank write port, all-bank
//            registered vector read, sequenced one-address-per-cycle clear.
//            Define SRAM_BYPASS_EN for write-first same-address collisions.
// Revision : 1.0
// ============================================================================
module banked_dual_sram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_WIDTH = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            Mem_Clear,
  input  logic                            Chip_Select,
  input  logic                            En_Write,
  input  logic [BANK_WIDTH-1:0]           Write_Bank,
  input  logic [ADDR_WIDTH-1:0]           Write_Addr,
  input  logic [DATA_WIDTH-1:0]           Write_Data,
  input  logic                            En_Read,
  input  logic [ADDR_WIDTH-1:0]           Read_Addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] Read_Data,
  output logic                            Read_Valid,
  output logic                            Clear_Busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_e                          state_q;
  logic [ADDR_WIDTH-1:0]           clr_addr_q;
  logic                            clear_busy_q;
  logic                            read_valid_q;
  logic [NUM_BANKS*DATA_WIDTH-1:0] read_data_q;
  logic [NUM_BANKS*DATA_WIDTH-1:0] w_read_vec;
  logic                            w_access;
  logic                            w_write;
  logic                            w_read;
  logic                            w_clear_write;

  // A pending clear request or an active clear sequence masks all user access.
  assign w_access      = !rst && (state_q == ST_IDLE) && !Mem_Clear && Chip_Select;
  assign w_write       = w_access && En_Write;
  assign w_read        = w_access && En_Read;
  assign w_clear_write = !rst && (state_q == ST_CLEAR);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic                  w_wr_hit;

    // Out-of-range bank selects match no bank and are dropped.
    assign w_wr_hit = w_write && (int'(Write_Bank) == b);

    always_ff @(posedge clk) begin
      if (w_clear_write) begin
        mem_q[clr_addr_q] <= '0;
      end else if (w_wr_hit) begin
        mem_q[Write_Addr] <= Write_Data;
      end
    end

`ifdef SRAM_BYPASS_EN
    assign w_read_vec[b*DATA_WIDTH +: DATA_WIDTH] =
      (w_wr_hit && (Write_Addr == Read_Addr)) ? Write_Data : mem_q[Read_Addr];
`else
    assign w_read_vec[b*DATA_WIDTH +: DATA_WIDTH] = mem_q[Read_Addr];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      clr_addr_q   <= '0;
      clear_busy_q <= 1'b0;
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
    end else begin
      read_valid_q <= w_read;
      if (w_read) begin
        read_data_q <= w_read_vec;
      end
      case (state_q)
        ST_IDLE: begin
          if (Mem_Clear) begin
            state_q      <= ST_CLEAR;
            clr_addr_q   <= '0;
            clear_busy_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // Counter saturates on the last address; no second pass.
          if (clr_addr_q == C_LAST_ADDR) begin
            state_q      <= ST_IDLE;
            clear_busy_q <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          clear_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign Read_Data  = read_data_q;
  assign Read_Valid = read_valid_q;
  assign Clear_Busy = clear_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_banked_dual_sram.sv
`default_nettype none
// Bench for banked_dual_sram: vector table plus directed clear/reset sequences;
// read results are checked through an expected-data queue.
module tb_banked_dual_sram;
  localparam int DW = 8, AW = 4, DEPTH = 16, NB = 4, BW = 2;

  logic            clk = 1'b0;
  logic            rst, Mem_Clear, Chip_Select, En_Write, En_Read;
  logic [BW-1:0]   Write_Bank;
  logic [AW-1:0]   Write_Addr, Read_Addr;
  logic [DW-1:0]   Write_Data;
  logic [NB*DW-1:0] Read_Data;
  logic            Read_Valid, Clear_Busy;

  banked_dual_sram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .NUM_BANKS(NB), .BANK_WIDTH(BW)
  ) dut (
    .clk(clk), .rst(rst), .Mem_Clear(Mem_Clear), .Chip_Select(Chip_Select),
    .En_Write(En_Write), .Write_Bank(Write_Bank), .Write_Addr(Write_Addr),
    .Write_Data(Write_Data), .En_Read(En_Read), .Read_Addr(Read_Addr),
    .Read_Data(Read_Data), .Read_Valid(Read_Valid), .Clear_Busy(Clear_Busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, mc, cs, we;
    logic [1:0]  wb;
    logic [3:0]  wa;
    logic [7:0]  wd;
    logic        re;
    logic [3:0]  ra;
    logic        exp_rv, chk;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
  } sb_t;

  sb_t         sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        exp_rv_drv = 1'b0;
  logic [7:0]  model [NB][DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v_idle();
    vec_t v = '0;
    return v;
  endfunction

  function automatic vec_t v_wr(input logic [1:0] b, input logic [3:0] a, input logic [7:0] d);
    vec_t v = '0;
    v.cs = 1'b1; v.we = 1'b1; v.wb = b; v.wa = a; v.wd = d;
    return v;
  endfunction

  function automatic vec_t v_rd(input logic [3:0] a, input logic [31:0] e);
    vec_t v = '0;
    v.cs = 1'b1; v.re = 1'b1; v.ra = a; v.exp_rv = 1'b1; v.chk = 1'b1; v.exp = e;
    return v;
  endfunction

  function automatic logic [31:0] mvec(input logic [3:0] a);
    return {model[3][a], model[2][a], model[1][a], model[0][a]};
  endfunction

  // Drive one cycle at the falling edge; return shortly after the rising edge.
  task automatic apply(input vec_t v);
    sb_t s;
    @(negedge clk);
    rst = v.rst; Mem_Clear = v.mc; Chip_Select = v.cs; En_Write = v.we;
    Write_Bank = v.wb; Write_Addr = v.wa; Write_Data = v.wd;
    En_Read = v.re; Read_Addr = v.ra;
    exp_rv_drv = v.exp_rv;
    if (v.exp_rv) begin
      s.chk = v.chk; s.data = v.exp;
      sb_q.push_back(s);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic fill_pattern();
    for (int b = 0; b < NB; b++) begin
      for (int a = 0; a < DEPTH; a++) begin
        model[b][a] = 8'(16 * b + a);
        apply(v_wr(2'(b), 4'(a), model[b][a]));
      end
    end
  endtask

  // Output monitor: valid strobe every cycle, data on reads, hold otherwise.
  logic        mon_exp, mon_rst;
  logic        hold_known = 1'b0;
  logic [31:0] hold_data = '0;
  sb_t         mon_s;
  always @(posedge clk) begin
    mon_exp = exp_rv_drv;
    mon_rst = rst;
    #1;
    check("read_valid", {31'd0, Read_Valid}, {31'd0, mon_exp});
    if (mon_exp) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard: queue empty, got %h, expected a queued entry", Read_Data);
      end else begin
        mon_s = sb_q.pop_front();
        if (mon_s.chk) begin
          check("read_data", Read_Data, mon_s.data);
          hold_data  = mon_s.data;
          hold_known = 1'b1;
        end else begin
          hold_known = 1'b0;
        end
      end
    end else if (mon_rst) begin
      check("reset_data", Read_Data, 32'd0);
      hold_data  = '0;
      hold_known = 1'b1;
    end else if (hold_known) begin
      check("hold_data", Read_Data, hold_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl [14];
  vec_t v;
  int   busy_cnt;

  initial begin
    rst = 1'b1; Mem_Clear = 1'b0; Chip_Select = 1'b0; En_Write = 1'b0; En_Read = 1'b0;
    Write_Bank = '0; Write_Addr = '0; Write_Data = '0; Read_Addr = '0;

    // Reset held two cycles with a read request present
    for (int i = 0; i < 2; i++) begin
      v = v_rd(4'd0, 32'd0); v.rst = 1'b1; v.exp_rv = 1'b0; v.chk = 1'b0;
      apply(v);
      check("busy_in_reset", {31'd0, Clear_Busy}, 32'd0);
    end
    v = v_rd(4'd0, 32'd0); v.chk = 1'b0;
    apply(v);
    apply(v_idle());

    fill_pattern();

    tbl[0]  = v_rd(4'd3,  32'h33231303);
    tbl[1]  = v_rd(4'd0,  32'h30201000);
    tbl[2]  = v_rd(4'd15, 32'h3F2F1F0F);
    tbl[3]  = v_rd(4'd5,  32'd0); tbl[3].cs = 1'b0; tbl[3].exp_rv = 1'b0; tbl[3].chk = 1'b0;
    tbl[4]  = v_wr(2'd0, 4'd5, 8'hFF); tbl[4].cs = 1'b0;
    tbl[5]  = v_rd(4'd5,  32'h35251505);
    tbl[6]  = v_wr(2'd2, 4'd7, 8'h11);
    tbl[7]  = v_rd(4'd7,  32'h37111707);
    tbl[8]  = v_wr(2'd2, 4'd7, 8'h22);
    tbl[8].re = 1'b1; tbl[8].ra = 4'd7; tbl[8].exp_rv = 1'b1; tbl[8].chk = 1'b1;
`ifdef SRAM_BYPASS_EN
    tbl[8].exp = 32'h37221707;
`else
    tbl[8].exp = 32'h37111707;
`endif
    tbl[9]  = v_rd(4'd7,  32'h37221707);
    tbl[10] = v_rd(4'd9,  32'd0); tbl[10].re = 1'b0; tbl[10].exp_rv = 1'b0; tbl[10].chk = 1'b0;
    tbl[11] = v_wr(2'd3, 4'd9, 8'hC3);
    tbl[12] = v_rd(4'd9,  32'hC3291909);
    tbl[13] = v_rd(4'd7,  32'h37221707);
    for (int i = 0; i < 14; i++) apply(tbl[i]);
    apply(v_idle());

    // Full clear with access attempts throughout the busy window
    fill_pattern();
    v = v_idle(); v.mc = 1'b1;
    apply(v);
    busy_cnt = (Clear_Busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < DEPTH; i++) begin
      v = v_wr(2'd2, 4'd0, 8'h77); v.re = 1'b1; v.ra = 4'(i);
      apply(v);
      if (Clear_Busy === 1'b1) busy_cnt++;
    end
    check("clear_busy_cycles", 32'(busy_cnt), 32'd16);
    check("clear_busy_end", {31'd0, Clear_Busy}, 32'd0);
    for (int b = 0; b < NB; b++) for (int a = 0; a < DEPTH; a++) model[b][a] = 8'h00;
    for (int a = 0; a < DEPTH; a++) apply(v_rd(4'(a), mvec(4'(a))));

    // Clear colliding with a write/read; second Mem_Clear mid-sequence ignored
    fill_pattern();
    v = v_wr(2'd1, 4'd5, 8'hAA); v.mc = 1'b1; v.re = 1'b1; v.ra = 4'd5;
    apply(v);
    busy_cnt = (Clear_Busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < DEPTH; i++) begin
      v = v_idle();
      if (i == 7) v.mc = 1'b1;
      apply(v);
      if (Clear_Busy === 1'b1) busy_cnt++;
    end
    check("collide_busy_cycles", 32'(busy_cnt), 32'd16);
    for (int b = 0; b < NB; b++) for (int a = 0; a < DEPTH; a++) model[b][a] = 8'h00;
    apply(v_rd(4'd5, mvec(4'd5)));
    apply(v_rd(4'd15, mvec(4'd15)));

    // Reset five clear edges into a clear
    fill_pattern();
    v = v_idle(); v.mc = 1'b1;
    apply(v);
    for (int i = 0; i < 5; i++) apply(v_idle());
    check("busy_before_rst", {31'd0, Clear_Busy}, 32'd1);
    v = v_idle(); v.rst = 1'b1;
    apply(v);
    check("busy_after_rst", {31'd0, Clear_Busy}, 32'd0);
    for (int b = 0; b < NB; b++) for (int a = 0; a < 5; a++) model[b][a] = 8'h00;
    for (int a = 0; a < DEPTH; a++) apply(v_rd(4'(a), mvec(4'(a))));
    apply(v_idle());
    apply(v_idle());

    check("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
